// File: rtl/win_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : win_scanner
//  Brief    : Sequential WIN_LEN-in-a-row scanner over a 2-bit-per-cell board
//             snapshot; reports winner, winning line anchor/direction and draw.
//  Revision : 1.0
// ============================================================================
module win_scanner #(
  parameter int ROWS    = 6,
  parameter int COLS    = 7,
  parameter int WIN_LEN = 4
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             newGame,
  input  logic                             start,
  input  logic [ROWS-1:0][COLS-1:0][1:0]   tokens,
  output logic                             busy,
  output logic                             done,
  output logic [1:0]                       winner,
  output logic                             draw,
  output logic [2:0]                       win_row,
  output logic [2:0]                       win_col,
  output logic [1:0]                       win_dir
);

  localparam int C_CELLS = ROWS * COLS;
  localparam int C_KW    = $clog2(C_CELLS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                         r_state;
  state_t                         w_next;
  logic [ROWS-1:0][COLS-1:0][1:0] r_snap;
  logic [C_KW-1:0]                r_anchor;
  logic [2:0]                     r_row;
  logic [2:0]                     r_col;
  logic [1:0]                     r_winner;
  logic                           r_draw;
  logic [2:0]                     r_win_row;
  logic [2:0]                     r_win_col;
  logic [1:0]                     r_win_dir;

  logic [4*C_CELLS-1:0]           w_hit;
  logic [3:0]                     w_dirs;
  logic                           w_any;
  logic                           w_last;
  logic                           w_full;
  logic [1:0]                     w_dir_sel;
  logic [1:0]                     w_val;

  function automatic logic f_run(input logic [2*WIN_LEN-1:0] cells);
    logic ok;
    ok = (cells[1:0] == 2'b01) || (cells[1:0] == 2'b10);
    for (int i = 1; i < WIN_LEN; i++)
      if (cells[2*i +: 2] != cells[1:0]) ok = 1'b0;
    return ok;
  endfunction

  // One hit bit per (anchor, direction); lines leaving the board are tied off.
  for (genvar gr = 0; gr < ROWS; gr++) begin : g_row
    for (genvar gc = 0; gc < COLS; gc++) begin : g_col
      for (genvar gd = 0; gd < 4; gd++) begin : g_dir
        localparam int C_DR  = (gd == 0) ? 0 : ((gd == 3) ? -1 : 1);
        localparam int C_DC  = (gd == 1) ? 0 : 1;
        localparam int C_ER  = gr + C_DR * (WIN_LEN - 1);
        localparam int C_EC  = gc + C_DC * (WIN_LEN - 1);
        localparam int C_BIT = 4 * (gr * COLS + gc) + gd;
        if (C_ER >= 0 && C_ER < ROWS && C_EC < COLS) begin : g_on
          logic [2*WIN_LEN-1:0] w_cells;
          for (genvar gi = 0; gi < WIN_LEN; gi++) begin : g_cell
            assign w_cells[2*gi +: 2] = r_snap[gr + C_DR*gi][gc + C_DC*gi];
          end
          assign w_hit[C_BIT] = f_run(w_cells);
        end else begin : g_off
          assign w_hit[C_BIT] = 1'b0;
        end
      end
    end
  end

  assign w_dirs = w_hit[{r_anchor, 2'b00} +: 4];
  assign w_any  = |w_dirs;
  assign w_last = (r_anchor == C_KW'(C_CELLS - 1));
  assign w_val  = r_snap[r_row][r_col];

  always_comb begin
    w_dir_sel = 2'd3;
    if (w_dirs[0])      w_dir_sel = 2'd0;
    else if (w_dirs[1]) w_dir_sel = 2'd1;
    else if (w_dirs[2]) w_dir_sel = 2'd2;
  end

  always_comb begin
    w_full = 1'b1;
    for (int c = 0; c < COLS; c++)
      if (r_snap[0][c] == 2'b00) w_full = 1'b0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (newGame) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (start) w_next = S_SCAN;
        S_SCAN:  if (w_any || w_last) w_next = S_DONE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_snap    <= '0;
      r_anchor  <= '0;
      r_row     <= '0;
      r_col     <= '0;
      r_winner  <= '0;
      r_draw    <= 1'b0;
      r_win_row <= '0;
      r_win_col <= '0;
      r_win_dir <= '0;
    end else if (newGame) begin
      r_snap    <= '0;
      r_anchor  <= '0;
      r_row     <= '0;
      r_col     <= '0;
      r_winner  <= '0;
      r_draw    <= 1'b0;
      r_win_row <= '0;
      r_win_col <= '0;
      r_win_dir <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_snap    <= tokens;
            r_anchor  <= '0;
            r_row     <= '0;
            r_col     <= '0;
            r_winner  <= '0;
            r_draw    <= 1'b0;
            r_win_row <= '0;
            r_win_col <= '0;
            r_win_dir <= '0;
          end
        end
        S_SCAN: begin
          if (w_any) begin
            r_winner  <= w_val;
            r_win_row <= r_row;
            r_win_col <= r_col;
            r_win_dir <= w_dir_sel;
          end else if (w_last) begin
            r_draw    <= w_full;
          end else begin
            r_anchor <= r_anchor + 1'b1;
            if (r_col == 3'(COLS - 1)) begin
              r_col <= '0;
              r_row <= r_row + 1'b1;
            end else begin
              r_col <= r_col + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy    = (r_state != S_IDLE);
  assign done    = (r_state == S_DONE);
  assign winner  = r_winner;
  assign draw    = r_draw;
  assign win_row = r_win_row;
  assign win_col = r_win_col;
  assign win_dir = r_win_dir;

endmodule
`default_nettype wire

// File: tb/tb_win_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_win_scanner
//  Brief    : Self-checking bench for win_scanner: reference scan model with a
//             per-cycle compare, directed board cases and randomized traffic.
//  Revision : 1.0
// ============================================================================
module tb_win_scanner;

  typedef logic [5:0][6:0][1:0] board_t;

  logic       clk;
  logic       rst_n;
  logic       newGame;
  logic       start;
  board_t     tokens;
  logic       busy;
  logic       done;
  logic [1:0] winner;
  logic       draw;
  logic [2:0] win_row;
  logic [2:0] win_col;
  logic [1:0] win_dir;

  int n_chk = 0;
  int n_err = 0;
  bit cmp_en = 0;

  win_scanner #(.ROWS(6), .COLS(7), .WIN_LEN(4)) dut (
    .clock   (clk),
    .reset   (rst_n),
    .newGame (newGame),
    .start   (start),
    .tokens  (tokens),
    .busy    (busy),
    .done    (done),
    .winner  (winner),
    .draw    (draw),
    .win_row (win_row),
    .win_col (win_col),
    .win_dir (win_dir)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: first line (row-major anchors, H/V/DR/UR order) of 4 equal P1/P2 cells.
  function automatic void ref_scan(input board_t b, output int lat, output logic [1:0] w,
                                   output logic [2:0] r, output logic [2:0] c,
                                   output logic [1:0] d, output logic dr);
    int  dr_t [4] = '{0, 1, 1, -1};
    int  dc_t [4] = '{1, 0, 1, 1};
    bit  found = 0;
    lat = 43; w = 0; r = 0; c = 0; d = 0; dr = 1;
    for (int k = 0; k < 42 && !found; k++) begin
      for (int dd = 0; dd < 4 && !found; dd++) begin
        int ar = k / 7;
        int ac = k % 7;
        int er = ar + 3 * dr_t[dd];
        int ec = ac + 3 * dc_t[dd];
        if (er >= 0 && er < 6 && ec < 7) begin
          logic [1:0] v = b[ar][ac];
          bit ok = (v == 2'b01 || v == 2'b10);
          for (int i = 1; i < 4; i++)
            if (b[ar + i*dr_t[dd]][ac + i*dc_t[dd]] != v) ok = 0;
          if (ok) begin
            found = 1; lat = k + 2; w = v; r = 3'(ar); c = 3'(ac); d = 2'(dd);
          end
        end
      end
    end
    for (int c0 = 0; c0 < 7; c0++)
      if (b[0][c0] == 2'b00) dr = 0;
    if (found) dr = 0;
  endfunction

  // Model timeline: m_el counts cycles since the accepted start (0 = idle).
  int         m_el, m_lat;
  logic [1:0] m_w, m_d, p_w, p_d;
  logic [2:0] m_r, m_c, p_r, p_c;
  logic       m_draw, p_draw;

  always @(posedge clk or negedge rst_n) begin : model
    int lat; logic [1:0] w, d; logic [2:0] r, c; logic dr;
    if (!rst_n || newGame) begin
      m_el <= 0; m_lat <= 0;
      m_w <= 0; m_d <= 0; m_r <= 0; m_c <= 0; m_draw <= 0;
    end else if (m_el == 0) begin
      if (start) begin
        ref_scan(tokens, lat, w, r, c, d, dr);
        m_lat <= lat; p_w <= w; p_d <= d; p_r <= r; p_c <= c; p_draw <= dr;
        m_el <= 1;
        m_w <= 0; m_d <= 0; m_r <= 0; m_c <= 0; m_draw <= 0;
      end
    end else if (m_el == m_lat) begin
      m_el <= 0;
    end else begin
      m_el <= m_el + 1;
      if (m_el + 1 == m_lat) begin
        m_w <= p_w; m_d <= p_d; m_r <= p_r; m_c <= p_c; m_draw <= p_draw;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy",    32'(busy),    32'(m_el != 0));
      chk("done",    32'(done),    32'(m_el != 0 && m_el == m_lat));
      chk("winner",  32'(winner),  32'(m_w));
      chk("draw",    32'(draw),    32'(m_draw));
      chk("win_row", 32'(win_row), 32'(m_r));
      chk("win_col", 32'(win_col), 32'(m_c));
      chk("win_dir", 32'(win_dir), 32'(m_d));
    end
  end

  function automatic board_t rand_board();
    board_t b;
    int pe = int'($urandom_range(30, 92));
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 7; c++) begin
        int x = int'($urandom_range(0, 99));
        if (x < pe)      b[r][c] = 2'b00;
        else if (x < 98) b[r][c] = 2'($urandom_range(1, 2));
        else             b[r][c] = 2'b11;
      end
    return b;
  endfunction

  // Starts a scan at a falling edge and counts cycles until done.
  task automatic do_scan(input string name, input board_t b, input int exp_lat,
                         input logic [1:0] ew, input logic [2:0] er, input logic [2:0] ec,
                         input logic [1:0] ed, input logic edraw,
                         input int flip_at, input board_t flip_b);
    int n;
    tokens = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; n = 1;
    chk({name, "_busy_c1"}, 32'(busy), 32'd1);
    chk({name, "_clr_c1"},  32'({winner, draw}), 32'd0);
    while (!done && n < 60) begin
      if (n == flip_at) tokens = flip_b;
      @(negedge clk);
      n++;
    end
    chk({name, "_latency"}, 32'(n), 32'(exp_lat));
    chk({name, "_result"},  32'({winner, win_row, win_col, win_dir, draw}),
                            32'({ew, er, ec, ed, edraw}));
    @(negedge clk);
  endtask

  task automatic watch_no_done(input string name, input int cycles);
    int dn = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      dn += int'(done);
    end
    chk(name, 32'(dn), 32'd0);
  endtask

  board_t b_empty, b_h, b_v, b_full, b_diag, b_p2;

  initial begin
    rst_n = 1'b0; start = 1'b0; newGame = 1'b0; tokens = '0;
    b_empty = '0;
    b_h = '0;    for (int c = 0; c < 4; c++) b_h[5][c] = 2'b01;
    b_v = '0;    for (int r = 2; r < 6; r++) b_v[r][6] = 2'b10;
    b_diag = '0; for (int i = 0; i < 4; i++) b_diag[5-i][i] = 2'b01;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 7; c++) begin
        b_full[r][c] = ((((c >> 1) + r) & 1) != 0) ? 2'b10 : 2'b01;
        b_p2[r][c]   = 2'b10;
      end

    @(negedge clk); @(negedge clk);
    chk("reset_outputs", 32'({busy, done, winner, draw, win_row, win_col, win_dir}), 32'd0);
    cmp_en = 1;
    rst_n = 1'b1;
    @(negedge clk);

    do_scan("empty", b_empty, 43, 2'b00, 3'd0, 3'd0, 2'd0, 1'b0, -1, b_empty);
    do_scan("horiz", b_h,     37, 2'b01, 3'd5, 3'd0, 2'd0, 1'b0, -1, b_empty);
    do_scan("vert",  b_v,     22, 2'b10, 3'd2, 3'd6, 2'd1, 1'b0, -1, b_empty);
    do_scan("full1", b_full,  43, 2'b00, 3'd0, 3'd0, 2'd0, 1'b1, -1, b_empty);
    do_scan("full2", b_full,  43, 2'b00, 3'd0, 3'd0, 2'd0, 1'b1, -1, b_empty);
    do_scan("diag",  b_diag,  37, 2'b01, 3'd5, 3'd0, 2'd3, 1'b0, 5, b_p2);

    // newGame mid-scan
    tokens = b_h; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    newGame = 1'b1;
    @(negedge clk); newGame = 1'b0;
    chk("ng_clear", 32'({busy, done, winner, draw, win_row, win_col, win_dir}), 32'd0);
    watch_no_done("ng_no_done", 45);

    // reset mid-scan
    do_scan("vert2", b_v, 22, 2'b10, 3'd2, 3'd6, 2'd1, 1'b0, -1, b_empty);
    tokens = b_h; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_clear", 32'({busy, done, winner, draw, win_row, win_col, win_dir}), 32'd0);
    rst_n = 1'b1;
    watch_no_done("rst_no_done", 45);

    // start together with newGame stays idle and clears sticky results
    do_scan("vert3", b_v, 22, 2'b10, 3'd2, 3'd6, 2'd1, 1'b0, -1, b_empty);
    start = 1'b1; newGame = 1'b1;
    @(negedge clk);
    start = 1'b0; newGame = 1'b0;
    chk("ng_start_idle", 32'({busy, winner}), 32'd0);
    @(negedge clk);
    chk("ng_start_idle2", 32'(busy), 32'd0);

    // randomized traffic: starts while busy, mid-scan token changes, newGame
    tokens = rand_board();
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      start   = ($urandom_range(0, 5) == 0);
      newGame = ($urandom_range(0, 250) == 0);
      if ($urandom_range(0, 20) == 0) tokens = rand_board();
    end
    start = 1'b0; newGame = 1'b0;
    repeat (50) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
